// File: rtl/wb_fifo_slave.sv
// Wishbone slave: CONTROL/STATUS/SCRATCH registers plus a 32-bit data FIFO port.
// Three-state handshake (IDLE -> ACK -> HOLD) gives at most one access per strobe.
module wb_fifo_slave #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic        wb_msk_i,
  input  logic        wb_sel_i,
  output logic        wb_ack_o,
  output logic        wb_int_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            int_q, int_d;
  logic            en_q, en_d;
  logic            ie_q, ie_d;
  logic [31:0]     scratch_q, scratch_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            push;
  logic [31:0]     mem [FIFO_DEPTH];

  logic            req, empty, full;
  logic [31:0]     ctrl_rd, status_rd;
  logic            unused_ok;

  assign unused_ok = ^{wb_adr_i[31:2], wb_msk_i, wb_sel_i};

  assign req   = (state_q == S_IDLE) && wb_stb_i && wb_cyc_i;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));

  always_comb begin
    ctrl_rd       = '0;
    ctrl_rd[1:0]  = {ie_q, en_q};
    status_rd     = '0;
    status_rd[0]  = empty;
    status_rd[1]  = full;
    status_rd[2]  = ovf_q;
    status_rd[3]  = udf_q;
    status_rd[8 +: CW] = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      int_q     <= 1'b0;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      scratch_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      int_q     <= int_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      scratch_q <= scratch_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage is not reset; a push racing a reset edge is orphaned by the pointer reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wb_dat_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (wb_stb_i && wb_cyc_i) state_d = S_ACK;
      S_ACK:  state_d = wb_cyc_i ? S_HOLD : S_IDLE;
      S_HOLD: if (!wb_stb_i || !wb_cyc_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d     = 1'b0;
    dat_d     = dat_q;
    int_d     = ie_q & (~empty | ovf_q);
    en_d      = en_q;
    ie_d      = ie_q;
    scratch_d = scratch_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    push      = 1'b0;
    if (req) begin
      ack_d = 1'b1;
      case (wb_adr_i[1:0])
        2'd0: begin
          if (wb_we_i) begin
            en_d = wb_dat_i[0];
            ie_d = wb_dat_i[1];
            if (wb_dat_i[2]) begin
              wr_ptr_d = '0;
              rd_ptr_d = '0;
              cnt_d    = '0;
            end
          end else begin
            dat_d = ctrl_rd;
          end
        end
        2'd1: begin
          if (wb_we_i) begin
            if (wb_dat_i[2]) ovf_d = 1'b0;
            if (wb_dat_i[3]) udf_d = 1'b0;
          end else begin
            dat_d = status_rd;
          end
        end
        2'd2: begin
          if (wb_we_i) scratch_d = wb_dat_i;
          else         dat_d     = scratch_q;
        end
        default: begin
          if (wb_we_i) begin
            if (en_q) begin
              if (full) begin
                ovf_d = 1'b1;
              end else begin
                push     = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                cnt_d    = cnt_q + CW'(1);
              end
            end
          end else if (en_q && !empty) begin
            dat_d    = mem[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d    = cnt_q - CW'(1);
          end else begin
            dat_d = '0;
            if (en_q) udf_d = 1'b1;
          end
        end
      endcase
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign wb_int_o = int_q;

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Directed bench for wb_fifo_slave: register map, FIFO order/wrap, stickies, handshake and reset.
module tb_wb_fifo_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_msk_i, wb_sel_i;
  logic        wb_ack_o, wb_int_o;

  int n_cmp = 0;
  int n_mis = 0;
  int last_lat;
  logic last_ack2;
  logic [31:0] r;

  always #5 clk = ~clk;

  wb_fifo_slave #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_msk_i(wb_msk_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .wb_int_o(wb_int_o)
  );

  // One classic transfer; stb/cyc drop as soon as ack is seen.
  task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    wb_we_i = we; wb_adr_i = {30'h2AAAAAAA, a}; wb_dat_i = d;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb_ack_o && n < 8);
    n_cmp++;
    if (!wb_ack_o) begin
      n_mis++;
      $display("FAIL bus_timeout: ack=%b after %0d cycles, required 1", wb_ack_o, n);
    end
    rd = wb_dat_o;
    last_lat = n;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    last_ack2 = wb_ack_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({wb_ack_o, wb_int_o, wb_dat_o} !== 34'h0) begin
      n_mis++; $display("FAIL reset_outputs: got %h required 0", {wb_ack_o, wb_int_o, wb_dat_o});
    end
    rst = 1'b0;
    bus(1'b0, 2'd0, 32'h0, r);
    n_cmp++; if (r !== 32'h0) begin n_mis++; $display("FAIL reset_ctrl: got %h required 00000000", r); end
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h1) begin n_mis++; $display("FAIL reset_status: got %h required 00000001", r); end
    bus(1'b0, 2'd2, 32'h0, r);
    n_cmp++; if (r !== 32'h0) begin n_mis++; $display("FAIL reset_scratch: got %h required 00000000", r); end
  endtask

  task automatic test_scratch();
    bus(1'b1, 2'd2, 32'hDEADBEEF, r);
    n_cmp++; if (last_lat !== 1) begin n_mis++; $display("FAIL wr_ack_latency: got %0d required 1", last_lat); end
    n_cmp++; if (last_ack2 !== 1'b0) begin n_mis++; $display("FAIL wr_ack_width: got %b required 0", last_ack2); end
    n_cmp++; if (r !== 32'h0) begin n_mis++; $display("FAIL wr_dat_hold: got %h required 00000000", r); end
    bus(1'b0, 2'd2, 32'h0, r);
    n_cmp++; if (r !== 32'hDEADBEEF) begin n_mis++; $display("FAIL scratch_rd: got %h required deadbeef", r); end
    n_cmp++; if (last_lat !== 1) begin n_mis++; $display("FAIL rd_ack_latency: got %0d required 1", last_lat); end
    n_cmp++; if (last_ack2 !== 1'b0) begin n_mis++; $display("FAIL rd_ack_width: got %b required 0", last_ack2); end
  endtask

  task automatic test_fifo_basic();
    bus(1'b1, 2'd0, 32'h3, r);
    for (int i = 1; i <= 3; i++) bus(1'b1, 2'd3, i, r);
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h300) begin n_mis++; $display("FAIL basic_status3: got %h required 00000300", r); end
    n_cmp++; if (wb_int_o !== 1'b1) begin n_mis++; $display("FAIL basic_int1: got %b required 1", wb_int_o); end
    for (int i = 1; i <= 3; i++) begin
      bus(1'b0, 2'd3, 32'h0, r);
      n_cmp++; if (r !== i) begin n_mis++; $display("FAIL basic_pop%0d: got %h required %h", i, r, i); end
    end
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h1) begin n_mis++; $display("FAIL basic_status0: got %h required 00000001", r); end
    n_cmp++; if (wb_int_o !== 1'b0) begin n_mis++; $display("FAIL basic_int0: got %b required 0", wb_int_o); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) bus(1'b1, 2'd3, 32'hA0 + i, r);
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, 2'd3, 32'h0, r);
      n_cmp++; if (r !== 32'hA0 + i) begin n_mis++; $display("FAIL prefill_pop%0d: got %h required %h", i, r, 32'hA0 + i); end
    end
    for (int i = 0; i < 17; i++) bus(1'b1, 2'd3, 32'h100 + i, r);
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h1006) begin n_mis++; $display("FAIL ovf_status: got %h required 00001006", r); end
    n_cmp++; if (wb_int_o !== 1'b1) begin n_mis++; $display("FAIL ovf_int: got %b required 1", wb_int_o); end
    bus(1'b1, 2'd1, 32'h4, r);
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h1002) begin n_mis++; $display("FAIL ovf_w1c: got %h required 00001002", r); end
    for (int i = 0; i < 16; i++) begin
      bus(1'b0, 2'd3, 32'h0, r);
      n_cmp++; if (r !== 32'h100 + i) begin n_mis++; $display("FAIL wrap_pop%0d: got %h required %h", i, r, 32'h100 + i); end
    end
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h1) begin n_mis++; $display("FAIL drained_status: got %h required 00000001", r); end
  endtask

  task automatic test_underflow();
    bus(1'b0, 2'd3, 32'h0, r);
    n_cmp++; if (r !== 32'h0) begin n_mis++; $display("FAIL udf_data: got %h required 00000000", r); end
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h9) begin n_mis++; $display("FAIL udf_status: got %h required 00000009", r); end
    bus(1'b1, 2'd1, 32'h8, r);
    bus(1'b1, 2'd0, 32'h0, r);
    bus(1'b1, 2'd3, 32'h55, r);
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h1) begin n_mis++; $display("FAIL dis_push_status: got %h required 00000001", r); end
    bus(1'b0, 2'd2, 32'h0, r);
    bus(1'b0, 2'd3, 32'h0, r);
    n_cmp++; if (r !== 32'h0) begin n_mis++; $display("FAIL dis_pop_data: got %h required 00000000", r); end
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h1) begin n_mis++; $display("FAIL dis_pop_status: got %h required 00000001", r); end
  endtask

  task automatic test_handshake();
    int acks;
    bus(1'b1, 2'd0, 32'h1, r);
    @(posedge clk); #1;
    wb_we_i = 1'b1; wb_adr_i = 32'h3; wb_dat_i = 32'hABC;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    acks = 0;
    repeat (7) begin
      @(posedge clk); #1;
      if (wb_ack_o) acks++;
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    n_cmp++; if (acks !== 1) begin n_mis++; $display("FAIL hold_acks: got %0d required 1", acks); end
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h100) begin n_mis++; $display("FAIL hold_count: got %h required 00000100", r); end
    // Drop cyc in ACK, re-raise one cycle later: a direct return to IDLE acks immediately.
    @(posedge clk); #1;
    wb_adr_i = 32'h2; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (wb_ack_o !== 1'b1) begin n_mis++; $display("FAIL cyc_drop_ack: got %b required 1", wb_ack_o); end
    wb_cyc_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_mis++; $display("FAIL cyc_drop_clear: got %b required 0", wb_ack_o); end
    wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (wb_ack_o !== 1'b1) begin n_mis++; $display("FAIL cyc_drop_idle: got %b required 1", wb_ack_o); end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_clear_and_reset();
    bus(1'b0, 2'd3, 32'h0, r);
    n_cmp++; if (r !== 32'hABC) begin n_mis++; $display("FAIL held_push_data: got %h required 00000abc", r); end
    for (int i = 0; i < 4; i++) bus(1'b1, 2'd3, 32'h200 + i, r);
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h400) begin n_mis++; $display("FAIL pre_clear_status: got %h required 00000400", r); end
    bus(1'b1, 2'd0, 32'h5, r);
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h1) begin n_mis++; $display("FAIL clear_status: got %h required 00000001", r); end
    bus(1'b0, 2'd0, 32'h0, r);
    n_cmp++; if (r !== 32'h1) begin n_mis++; $display("FAIL clear_ctrl: got %h required 00000001", r); end
    bus(1'b1, 2'd0, 32'h3, r);
    bus(1'b1, 2'd3, 32'h77, r);
    bus(1'b0, 2'd2, 32'h0, r);
    n_cmp++; if ({wb_int_o, r} !== {1'b1, 32'hDEADBEEF}) begin
      n_mis++; $display("FAIL pre_rst_state: got %h required 1deadbeef", {wb_int_o, r});
    end
    @(posedge clk); #1;
    wb_we_i = 1'b1; wb_adr_i = 32'h3; wb_dat_i = 32'h88;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({wb_ack_o, wb_int_o, wb_dat_o} !== 34'h0) begin
      n_mis++; $display("FAIL rst_in_hold: got %h required 0", {wb_ack_o, wb_int_o, wb_dat_o});
    end
    rst = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    bus(1'b0, 2'd1, 32'h0, r);
    n_cmp++; if (r !== 32'h1) begin n_mis++; $display("FAIL post_rst_status: got %h required 00000001", r); end
    bus(1'b0, 2'd0, 32'h0, r);
    n_cmp++; if (r !== 32'h0) begin n_mis++; $display("FAIL post_rst_ctrl: got %h required 00000000", r); end
  endtask

  initial begin
    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    wb_we_i = 1'b0; wb_msk_i = 1'b0; wb_sel_i = 1'b0;
    test_reset();
    test_scratch();
    test_fifo_basic();
    test_overflow();
    test_underflow();
    test_handshake();
    test_clear_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
